// File: rtl/radio_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : radio_pkg -- shared FSM state, default timing constants, counter sizing
// Rev    : 1.0
//------------------------------------------------------------------------------
package radio_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2
  } chan_state_t;

  localparam int DEF_MIN_US       = 987;
  localparam int DEF_MIN_PULSE_US = 500;
  localparam int DEF_MAX_PULSE_US = 2500;
  localparam int DEF_TIMEOUT_US   = 100000;

  // Counter must hold MAX_PULSE_US+1 so an over-long pulse is distinguishable.
  function automatic int cnt_width(input int max_pulse_us);
    return $clog2(max_pulse_us + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/radio_chan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : radio_chan -- one PWM channel: synchroniser, width FSM, command mapping
//          (signal-loss failsafe when RADIO_FAILSAFE_EN is defined)
// Rev    : 1.0
//------------------------------------------------------------------------------
module radio_chan
  import radio_pkg::*;
#(
  parameter int CMD_W        = 10,
  parameter int MIN_US       = DEF_MIN_US,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int FAILSAFE_CMD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pwm,
  output logic [CMD_W-1:0] o_cmd,
  output logic             o_cmd_vld,
  output logic             o_lost
);

  localparam int               CNT_W       = cnt_width(MAX_PULSE_US);
  localparam int               MAX_US      = MIN_US + (1 << CMD_W) - 1;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_SAT   = CNT_W'(MAX_PULSE_US + 1);
  localparam logic [31:0]      c_MIN_US    = 32'(MIN_US);
  localparam logic [31:0]      c_MAX_US    = 32'(MAX_US);
  localparam logic [31:0]      c_MIN_PULSE = 32'(MIN_PULSE_US);
  localparam logic [31:0]      c_MAX_PULSE = 32'(MAX_PULSE_US);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [1:0]       r_warm;
  chan_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CMD_W-1:0] r_cmd;
  logic             r_vld;

  logic             w_rise;
  logic             w_fall;
  logic             w_accept;
  logic [31:0]      w_width;
  logic [CMD_W-1:0] w_map;

  assign w_rise   = r_sync2 & ~r_prev;
  assign w_fall   = ~r_sync2 & r_prev;
  assign w_width  = 32'(r_cnt);
  assign w_accept = (r_state == HIGH) && w_fall &&
                    (w_width >= c_MIN_PULSE) && (w_width <= c_MAX_PULSE);

  always_comb begin
    w_map = CMD_W'(w_width - c_MIN_US);
    if (w_width < c_MIN_US) begin
      w_map = '0;
    end else if (w_width > c_MAX_US) begin
      w_map = '1;
    end
  end

  // r_warm marks when r_sync2 first holds a real sample rather than its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_warm != 2'd2) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

`ifdef RADIO_FAILSAFE_EN
  localparam int              TO_W      = $clog2(TIMEOUT_US + 1);
  localparam logic [TO_W-1:0] c_TO_MAX  = TO_W'(TIMEOUT_US);
  localparam logic [TO_W-1:0] c_TO_PRE  = TO_W'(TIMEOUT_US - 1);
  localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);
  localparam logic [CMD_W-1:0] c_FS_CMD = CMD_W'(FAILSAFE_CMD);

  logic [TO_W-1:0] r_to;
  logic            r_lost;

  assign o_lost = r_lost;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_US == FAILSAFE_CMD);
  assign o_lost       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_LOW;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_vld   <= 1'b0;
`ifdef RADIO_FAILSAFE_EN
      r_to    <= '0;
      r_lost  <= 1'b1;
`endif
    end else begin
      r_vld <= w_accept;
      case (r_state)
        WAIT_LOW: begin
          if (!r_sync2 && (r_warm == 2'd2)) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_cnt   <= c_CNT_ONE;
          end
        end
        HIGH: begin
          if (w_fall) begin
            r_state <= IDLE;
          end else if (r_cnt != c_CNT_SAT) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: r_state <= WAIT_LOW;
      endcase
`ifdef RADIO_FAILSAFE_EN
      if (w_accept) begin
        r_to   <= '0;
        r_lost <= 1'b0;
      end else if (r_to != c_TO_MAX) begin
        r_to <= r_to + c_TO_ONE;
        if (r_to == c_TO_PRE) begin
          r_lost <= 1'b1;
          r_cmd  <= c_FS_CMD;
        end
      end
`endif
      if (w_accept) begin
        r_cmd <= w_map;
      end
    end
  end

  assign o_cmd     = r_cmd;
  assign o_cmd_vld = r_vld;

endmodule
`default_nettype wire

// File: rtl/radio_rx.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : radio_rx -- N_CH-channel RC PWM receiver, 1 us ticks on clk_1M
//          Optional signal-loss failsafe: define RADIO_FAILSAFE_EN
// Rev    : 1.0
//------------------------------------------------------------------------------
module radio_rx
  import radio_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int CMD_W        = 10,
  parameter int MIN_US       = DEF_MIN_US,
  parameter int MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int FAILSAFE_CMD = 0
) (
  input  logic                  clk_1M,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       radio,
  output logic [N_CH*CMD_W-1:0] cmd,
  output logic [N_CH-1:0]       cmd_vld,
  output logic [N_CH-1:0]       lost
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    radio_chan #(
      .CMD_W        (CMD_W),
      .MIN_US       (MIN_US),
      .MIN_PULSE_US (MIN_PULSE_US),
      .MAX_PULSE_US (MAX_PULSE_US),
      .TIMEOUT_US   (TIMEOUT_US),
      .FAILSAFE_CMD (FAILSAFE_CMD)
    ) u_chan (
      .clk       (clk_1M),
      .rst_n     (rst_n),
      .i_pwm     (radio[gi]),
      .o_cmd     (cmd[gi*CMD_W +: CMD_W]),
      .o_cmd_vld (cmd_vld[gi]),
      .o_lost    (lost[gi])
    );
  end

endmodule
`default_nettype wire
